ahb_uart: RTL and testbench



---
 rtl/uart_pkg.sv | 23 ++
 rtl/bus_protocol_if.sv | 24 ++
 rtl/uart_baud_counter.sv | 32 +++
 rtl/ahb_uart.sv | 243 ++++++++++++++++++++++++
 tb/tb_ahb_uart.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, state encoding and status bit indices for the UART
package uart_pkg;

  localparam logic [31:0] RXSTATE_ADDR = 32'h00;
  localparam logic [31:0] RXDATA_ADDR  = 32'h04;
  localparam logic [31:0] BAUD_ADDR    = 32'h08;
  localparam logic [31:0] TXSTATE_ADDR = 32'h10;
  localparam logic [31:0] TXDATA_ADDR  = 32'h18;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int RX_VALID_BIT  = 0;
  localparam int OVERRUN_BIT   = 1;
  localparam int FRAME_ERR_BIT = 2;
  localparam int TX_BUSY_BIT   = 0;

  localparam logic [15:0] MIN_BAUD_DIV = 16'd2;

  function automatic logic [15:0] clamp_baud(input logic [15:0] div);
    return (div < MIN_BAUD_DIV) ? MIN_BAUD_DIV : div;
  endfunction

endpackage

// File: rtl/bus_protocol_if.sv
// rtl/bus_protocol_if.sv - generic single-cycle register bus between protocol adapter and peripherals
interface bus_protocol_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    wen;
  logic                    ren;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] strobe;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    error;
  logic                    request_stall;

  modport peripheral_vital (
    input  wen, ren, addr, wdata, strobe,
    output rdata, error, request_stall
  );

  modport requester (
    output wen, ren, addr, wdata, strobe,
    input  rdata, error, request_stall
  );
endinterface

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - loadable bit-period down-counter with end-of-bit and mid-bit ticks
module uart_baud_counter (
  input  logic        clk,
  input  logic        nReset,
  input  logic        load,
  input  logic [15:0] div,
  output logic        bit_tick,
  output logic        half_tick
);

  logic [15:0] div_q;
  logic [15:0] count_q;

  // The divisor is captured on load so a BAUD write never disturbs a frame in flight.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      div_q   <= 16'd2;
      count_q <= '0;
    end else if (load) begin
      div_q   <= div;
      count_q <= div - 16'd1;
    end else if (count_q == 16'd0) begin
      count_q <= div_q - 16'd1;
    end else begin
      count_q <= count_q - 16'd1;
    end
  end

  assign bit_tick  = !load && (count_q == 16'd0);
  assign half_tick = !load && (count_q == (div_q - (div_q >> 1)));

endmodule

// File: rtl/ahb_uart.sv
// rtl/ahb_uart.sv - 8N1 UART with TX/RX holding registers; UART_FLOW_CONTROL_EN enables RTS/CTS
module ahb_uart
  import uart_pkg::*;
#(
  parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd8
) (
  input  logic clk,
  input  logic nReset,
  input  logic rx,
  output logic tx,
  input  logic cts,
  output logic rts,
  bus_protocol_if.peripheral_vital bp
);

  logic [15:0] baud_q;
  logic [15:0] baud_wr;
  logic        rx_valid_q, overrun_q, frame_err_q;
  logic [7:0]  rx_data_q;
  logic        tx_busy_q;
  logic [7:0]  tx_hold_q;
  logic        cts_ok;

  logic [31:0] reg_addr;
  logic        sel_rxstate, sel_rxdata, sel_baud, sel_txstate, sel_txdata;
  logic        mapped, ro_hit, rd_rxdata, wr_baud, tx_accept;
  logic [31:0] rdata_c;
  logic        unused_bus;

  assign reg_addr    = {bp.addr[31:2], 2'b00};
  assign sel_rxstate = (reg_addr == RXSTATE_ADDR);
  assign sel_rxdata  = (reg_addr == RXDATA_ADDR);
  assign sel_baud    = (reg_addr == BAUD_ADDR);
  assign sel_txstate = (reg_addr == TXSTATE_ADDR);
  assign sel_txdata  = (reg_addr == TXDATA_ADDR);
  assign mapped      = sel_rxstate | sel_rxdata | sel_baud | sel_txstate | sel_txdata;
  assign ro_hit      = sel_rxstate | sel_rxdata | sel_txstate;
  assign rd_rxdata   = bp.ren & sel_rxdata;
  assign wr_baud     = bp.wen & sel_baud & (|bp.strobe[1:0]);
  assign tx_accept   = bp.wen & sel_txdata & bp.strobe[0] & ~tx_busy_q;
  assign unused_bus  = ^{bp.addr[1:0], bp.wdata[31:16], bp.strobe[3:2]};

  always_comb begin
    rdata_c = '0;
    if (bp.ren) begin
      if (sel_rxstate) begin
        rdata_c[RX_VALID_BIT]  = rx_valid_q;
        rdata_c[OVERRUN_BIT]   = overrun_q;
        rdata_c[FRAME_ERR_BIT] = frame_err_q;
      end else if (sel_rxdata) begin
        rdata_c[7:0] = rx_data_q;
      end else if (sel_baud) begin
        rdata_c[15:0] = baud_q;
      end else if (sel_txstate) begin
        rdata_c[TX_BUSY_BIT] = tx_busy_q;
      end
    end
  end

  assign bp.rdata         = rdata_c;
  assign bp.error         = (bp.ren & (~mapped | sel_txdata)) |
                            (bp.wen & (~mapped | ro_hit | (sel_txdata & tx_busy_q)));
  assign bp.request_stall = 1'b0;

  assign baud_wr = {bp.strobe[1] ? bp.wdata[15:8] : baud_q[15:8],
                    bp.strobe[0] ? bp.wdata[7:0]  : baud_q[7:0]};

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      baud_q <= DEFAULT_BAUD_DIV;
    end else if (wr_baud) begin
      baud_q <= clamp_baud(baud_wr);
    end
  end

  // ---------------- transmit path ----------------
  uart_state_t tx_state_q, tx_state_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_cnt_q, tx_cnt_d;
  logic        tx_q, tx_d, tx_done;
  logic        tx_bit_tick, unused_tx_half_tick;

  uart_baud_counter u_tx_baud (
    .clk       (clk),
    .nReset    (nReset),
    .load      (tx_state_q == IDLE),
    .div       (baud_q),
    .bit_tick  (tx_bit_tick),
    .half_tick (unused_tx_half_tick)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_done    = 1'b0;
    tx_d       = 1'b1;
    case (tx_state_q)
      IDLE: if (tx_busy_q && cts_ok) begin
        tx_state_d = START;
        tx_shift_d = tx_hold_q;
        tx_cnt_d   = 3'd0;
      end
      START: if (tx_bit_tick) tx_state_d = DATA;
      DATA: if (tx_bit_tick) begin
        if (tx_cnt_q == 3'd7) begin
          tx_state_d = STOP;
        end else begin
          tx_cnt_d   = tx_cnt_q + 3'd1;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
        end
      end
      STOP: if (tx_bit_tick) begin
        tx_state_d = IDLE;
        tx_done    = 1'b1;
      end
      default: tx_state_d = IDLE;
    endcase
    // Line level is registered from the next state so tx moves on the same edge as the FSM.
    case (tx_state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = tx_shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      tx_state_q <= IDLE;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_hold_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_q       <= tx_d;
      if (tx_accept) begin
        tx_hold_q <= bp.wdata[7:0];
        tx_busy_q <= 1'b1;
      end else if (tx_done) begin
        tx_busy_q <= 1'b0;
      end
    end
  end

  assign tx = tx_q;

  // ---------------- receive path ----------------
  uart_state_t rx_state_q, rx_state_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_cnt_q, rx_cnt_d;
  logic        rx_meta_q, rx_sync_q, rx_prev_q, rx_fall, rx_done;
  logic        rx_bit_tick, rx_half_tick;

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  uart_baud_counter u_rx_baud (
    .clk       (clk),
    .nReset    (nReset),
    .load      (rx_state_q == IDLE),
    .div       (baud_q),
    .bit_tick  (rx_bit_tick),
    .half_tick (rx_half_tick)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_cnt_d   = rx_cnt_q;
    rx_done    = 1'b0;
    case (rx_state_q)
      IDLE: if (rx_fall) rx_state_d = START;
      START: begin
        if (rx_half_tick && rx_sync_q) begin
          rx_state_d = IDLE;
        end else if (rx_bit_tick) begin
          rx_state_d = DATA;
          rx_cnt_d   = 3'd0;
        end
      end
      DATA: begin
        if (rx_half_tick) rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        if (rx_bit_tick) begin
          if (rx_cnt_q == 3'd7) rx_state_d = STOP;
          else                  rx_cnt_d   = rx_cnt_q + 3'd1;
        end
      end
      // Returning to IDLE at mid-stop leaves room to catch a back-to-back start bit.
      STOP: if (rx_half_tick) begin
        rx_state_d = IDLE;
        rx_done    = 1'b1;
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= IDLE;
      rx_shift_q  <= '0;
      rx_cnt_q    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_cnt_q   <= rx_cnt_d;
      // A completing byte outranks a same-cycle RXDATA read.
      if (rx_done) begin
        rx_data_q   <= rx_shift_q;
        rx_valid_q  <= 1'b1;
        overrun_q   <= rd_rxdata ? 1'b0 : (overrun_q | rx_valid_q);
        frame_err_q <= ~rx_sync_q | (frame_err_q & ~rd_rxdata);
      end else if (rd_rxdata) begin
        rx_valid_q  <= 1'b0;
        overrun_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end
    end
  end

`ifdef UART_FLOW_CONTROL_EN
  assign cts_ok = cts;
  assign rts    = ~rx_valid_q;
`else
  logic unused_cts;
  assign unused_cts = cts;
  assign cts_ok     = 1'b1;
  assign rts        = 1'b1;
`endif

endmodule

// File: tb/tb_ahb_uart.sv
// tb/tb_ahb_uart.sv - scoreboard bench for ahb_uart (honours UART_FLOW_CONTROL_EN)
module tb_ahb_uart;

  logic clk = 1'b0;
  logic nReset, rx, cts;
  logic tx, rts;

  always #5 clk = ~clk;

  bus_protocol_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bp_if ();

  ahb_uart #(.DEFAULT_BAUD_DIV(16'd8)) dut (
    .clk    (clk),
    .nReset (nReset),
    .rx     (rx),
    .tx     (tx),
    .cts    (cts),
    .rts    (rts),
    .bp     (bp_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  logic exp_valid = 1'b0, exp_ovr = 1'b0, exp_ferr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic err);
    @(negedge clk);
    bp_if.addr = a; bp_if.wdata = d; bp_if.strobe = s; bp_if.wen = 1'b1;
    #1 err = bp_if.error;
    @(posedge clk);
    #1 bp_if.wen = 1'b0; bp_if.strobe = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(negedge clk);
    bp_if.addr = a; bp_if.ren = 1'b1;
    #1 d = bp_if.rdata; err = bp_if.error;
    @(posedge clk);
    #1 bp_if.ren = 1'b0;
  endtask

  task automatic send_tx(input logic [7:0] b, output logic err);
    bus_write(32'h18, {24'h0, b}, 4'hF, err);
    if (!err) tx_exp_q.push_back(b);
  endtask

  // Waits for a start bit, then samples each bit at mid-period for BAUD=8.
  task automatic capture_tx(output int lat, output logic [7:0] b, output logic stop_v);
    lat = 0; b = 8'h00; stop_v = 1'b0;
    while (tx !== 1'b0 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (tx !== 1'b0) begin
      lat = -1;
      return;
    end
    repeat (4) @(posedge clk);
    #1 check_eq("tx_start_bit", 32'(tx), 32'h0);
    for (int i = 0; i < 8; i++) begin
      repeat (8) @(posedge clk);
      #1 b[i] = tx;
    end
    repeat (8) @(posedge clk);
    #1 stop_v = tx;
  endtask

  task automatic tx_score(input logic [7:0] b);
    logic [7:0] e;
    e = 8'hxx;
    if (tx_exp_q.size() > 0) e = tx_exp_q.pop_front();
    check_eq("tx_byte", {24'h0, b}, {24'h0, e});
  endtask

  task automatic count_tx_low(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) n++;
    end
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_v);
    if (exp_valid) begin
      exp_ovr = 1'b1;
      rx_exp_q.delete();
    end
    rx_exp_q.push_back(b);
    exp_valid = 1'b1;
    if (!stop_v) exp_ferr = 1'b1;
    @(negedge clk) rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (8) @(negedge clk);
    end
    rx = stop_v;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic rx_check_state(input string tag);
    logic [31:0] d;
    logic e, exp_rts;
    bus_read(32'h00, d, e);
    check_eq(tag, d, {29'h0, exp_ferr, exp_ovr, exp_valid});
`ifdef UART_FLOW_CONTROL_EN
    exp_rts = ~exp_valid;
`else
    exp_rts = 1'b1;
`endif
    check_eq({tag, "_rts"}, 32'(rts), 32'(exp_rts));
  endtask

  task automatic rx_score();
    logic [31:0] d;
    logic e;
    logic [7:0] x;
    x = 8'hxx;
    bus_read(32'h04, d, e);
    if (rx_exp_q.size() > 0) x = rx_exp_q.pop_front();
    check_eq("rx_byte", d, {24'h0, x});
    exp_valid = 1'b0; exp_ovr = 1'b0; exp_ferr = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e, sb;
    logic [7:0]  b;
    int          lat, lows;

    nReset = 1'b0; rx = 1'b1; cts = 1'b1;
    bp_if.wen = 1'b0; bp_if.ren = 1'b0; bp_if.addr = '0; bp_if.wdata = '0; bp_if.strobe = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) nReset = 1'b1;
    #1;
    check_eq("rst_tx", 32'(tx), 32'h1);
    check_eq("rst_rts", 32'(rts), 32'h1);
    check_eq("rst_error", 32'(bp_if.error), 32'h0);
    check_eq("rst_rdata_idle", bp_if.rdata, 32'h0);
    check_eq("rst_stall", 32'(bp_if.request_stall), 32'h0);
    bus_read(32'h08, d, e);
    check_eq("rst_baud", d, 32'h8);
    check_eq("rst_baud_err", 32'(e), 32'h0);
    bus_read(32'h00, d, e);
    check_eq("rst_rxstate", d, 32'h0);
    bus_read(32'h10, d, e);
    check_eq("rst_txstate", d, 32'h0);

    send_tx(8'h0F, e);
    check_eq("tx_wr_err", 32'(e), 32'h0);
    check_eq("tx_before_start", 32'(tx), 32'h1);
    fork
      capture_tx(lat, b, sb);
      begin
        repeat (20) @(posedge clk);
        bus_read(32'h10, d, e);
        check_eq("txstate_busy", d, 32'h1);
        send_tx(8'h55, e);
        check_eq("tx_busy_wr_err", 32'(e), 32'h1);
      end
    join
    check_eq("tx_start_lat", 32'(lat), 32'h1);
    tx_score(b);
    check_eq("tx_stop_bit", 32'(sb), 32'h1);
    bus_read(32'h10, d, e);
    check_eq("txstate_in_stop", d, 32'h1);
    repeat (3) @(posedge clk);
    bus_read(32'h10, d, e);
    check_eq("txstate_done", d, 32'h0);
    count_tx_low(30, lows);
    check_eq("tx_no_extra_frame", 32'(lows), 32'h0);

    bus_read(32'h20, d, e);
    check_eq("unmapped_rd_err", 32'(e), 32'h1);
    check_eq("unmapped_rdata", d, 32'h0);
    bus_write(32'h20, 32'h1, 4'hF, e);
    check_eq("unmapped_wr_err", 32'(e), 32'h1);
    bus_write(32'h00, 32'h7, 4'hF, e);
    check_eq("ro_wr_err", 32'(e), 32'h1);
    bus_read(32'h18, d, e);
    check_eq("txdata_rd_err", 32'(e), 32'h1);

    bus_write(32'h08, 32'h1, 4'hF, e);
    bus_read(32'h08, d, e);
    check_eq("baud_clamp", d, 32'h2);
    bus_write(32'h08, 32'h1234, 4'h1, e);
    bus_read(32'h08, d, e);
    check_eq("baud_strobe0", d, 32'h34);
    bus_write(32'h08, 32'h8, 4'hF, e);
    bus_read(32'h08, d, e);
    check_eq("baud_restore", d, 32'h8);

    rx_send(8'hA5, 1'b1);
    rx_check_state("rx_valid");
    rx_score();
    rx_check_state("rx_cleared");
    rx_send(8'h3C, 1'b0);
    rx_check_state("rx_frame_err");
    rx_score();
    rx_check_state("rx_ferr_cleared");
    rx_send(8'h11, 1'b1);
    rx_send(8'h22, 1'b1);
    rx_check_state("rx_overrun");
    rx_score();
    rx_check_state("rx_ovr_cleared");
    @(negedge clk) rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    rx_check_state("rx_glitch");

`ifdef UART_FLOW_CONTROL_EN
    @(negedge clk) cts = 1'b0;
    bus_write(32'h18, 32'h0F, 4'hF, e);
    check_eq("fc_wr_err", 32'(e), 32'h0);
    count_tx_low(20, lows);
    check_eq("fc_tx_held", 32'(lows), 32'h0);
    bus_read(32'h10, d, e);
    check_eq("fc_txstate", d, 32'h1);
    @(negedge clk) cts = 1'b1;
    @(posedge clk);
    #1 check_eq("fc_start_on_cts", 32'(tx), 32'h0);
    #2 nReset = 1'b0;
    #1 check_eq("fc_reset_abort_tx", 32'(tx), 32'h1);
    @(negedge clk) nReset = 1'b1;
    bus_read(32'h10, d, e);
    check_eq("fc_txstate_after_rst", d, 32'h0);
`else
    @(negedge clk) cts = 1'b0;
    send_tx(8'h3C, e);
    capture_tx(lat, b, sb);
    check_eq("nofc_start_lat", 32'(lat), 32'h1);
    tx_score(b);
    check_eq("nofc_stop_bit", 32'(sb), 32'h1);
    cts = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
